// File: rtl/register_file_np_pkg.sv
// Shared widths, derived sizes and read-source encoding for the multi-port register file.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 1 << RF_ADDR_WIDTH;
    localparam int RF_MIN_READ   = 1;
    localparam int RF_MAX_READ   = 4;

    typedef enum logic [1:0] {
        SRC_MEM    = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } rd_src_e;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int rf_flat_width(input int num_slices, input int slice_width);
        return num_slices * slice_width;
    endfunction

endpackage

// File: rtl/register_file_np_mux_nx1.sv
// Generic 2^SEL_WIDTH-to-1 word multiplexer over a flattened input bus; purely combinational.
module mux_nx1 #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic [(WIDTH << SEL_WIDTH)-1:0] din,
    input  logic [SEL_WIDTH-1:0]            sel,
    output logic [WIDTH-1:0]                dout
);

    localparam int NUM_IN = 1 << SEL_WIDTH;

    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                dout = din[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/register_file_np.sv
// Register file: one synchronous write port, NUM_READ registered read ports with
// per-port enable, valid flag, zero-register option and write-to-read bypass.
module register_file_np
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           WE,
    input  logic [ADDR_WIDTH-1:0]          WADDR,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [NUM_READ-1:0]            RE,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] RADDR,
    output logic [NUM_READ*DATA_WIDTH-1:0] RDATA,
    output logic [NUM_READ-1:0]            RVALID
);

    localparam int DEPTH      = rf_depth(ADDR_WIDTH);
    localparam int FLAT_WIDTH = rf_flat_width(DEPTH, DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FLAT_WIDTH-1:0] mem_flat;
    logic                  zero_en;
    logic                  wr_accept;

    assign zero_en   = (ZERO_REG != 0);
    // With the zero register enabled, writes to address 0 are silently dropped.
    assign wr_accept = WE && !(zero_en && (WADDR == '0));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[WADDR] <= WDATA;
        end
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_flat
        assign mem_flat[w*DATA_WIDTH +: DATA_WIDTH] = mem[w];
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr_p;
        logic [DATA_WIDTH-1:0] mem_word;
        logic [DATA_WIDTH-1:0] rd_next;
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;
        rd_src_e               src;

        assign raddr_p = RADDR[p*ADDR_WIDTH +: ADDR_WIDTH];

        mux_nx1 #(
            .WIDTH     (DATA_WIDTH),
            .SEL_WIDTH (ADDR_WIDTH)
        ) u_mux (
            .din  (mem_flat),
            .sel  (raddr_p),
            .dout (mem_word)
        );

        // Zero register outranks bypass so a dropped write to 0 never leaks through.
        always_comb begin
            src = SRC_MEM;
            if (zero_en && (raddr_p == '0)) begin
                src = SRC_ZERO;
            end else if (WE && (WADDR == raddr_p)) begin
                src = SRC_BYPASS;
            end
            case (src)
                SRC_ZERO:   rd_next = '0;
                SRC_BYPASS: rd_next = WDATA;
                default:    rd_next = mem_word;
            endcase
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= RE[p];
                if (RE[p]) begin
                    rdata_q <= rd_next;
                end
            end
        end

        assign RDATA[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        assign RVALID[p]                         = rvalid_q;
    end

endmodule

// File: tb/tb_register_file_np.sv
// Directed scoreboard bench for register_file_np: default 32x32 two-port instance with
// the zero register, plus an 8x8 four-port instance without it.
module tb_register_file_np;

    typedef struct {
        string       tag;
        bit          sweep;
        int          port;
        logic [31:0] data;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic        clk = 1'b0;
    logic        rst;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;

    logic        s_we;
    logic [2:0]  s_waddr;
    logic [7:0]  s_wdata;
    logic [3:0]  s_re;
    logic [11:0] s_raddr;
    logic [31:0] s_rdata;
    logic [3:0]  s_rvalid;

    always #5 clk = ~clk;

    register_file_np #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_READ   (2),
        .ZERO_REG   (1)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .WE     (we),
        .WADDR  (waddr),
        .WDATA  (wdata),
        .RE     (re),
        .RADDR  (raddr),
        .RDATA  (rdata),
        .RVALID (rvalid)
    );

    register_file_np #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .NUM_READ   (4),
        .ZERO_REG   (0)
    ) dut_s (
        .CLK    (clk),
        .RST    (rst),
        .WE     (s_we),
        .WADDR  (s_waddr),
        .WDATA  (s_wdata),
        .RE     (s_re),
        .RADDR  (s_raddr),
        .RDATA  (s_rdata),
        .RVALID (s_rvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input bit sweep, input int port,
                             input logic [31:0] data, input logic valid);
        exp_t e;
        e.tag   = tag;
        e.sweep = sweep;
        e.port  = port;
        e.data  = data;
        e.valid = valid;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for it.
    task automatic step();
        exp_t        e;
        logic [31:0] obs_d;
        logic        obs_v;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sweep) begin
                obs_d = {24'h0, s_rdata[e.port*8 +: 8]};
                obs_v = s_rvalid[e.port];
            end else begin
                obs_d = rdata[e.port*32 +: 32];
                obs_v = rvalid[e.port];
            end
            check({e.tag, "_data"}, obs_d, e.data);
            check({e.tag, "_valid"}, {31'h0, obs_v}, {31'h0, e.valid});
        end
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_re = '0; s_raddr = '0;
        #2;
        check("por_rdata", rdata[31:0], 32'h0);
        check("por_rvalid", {30'h0, rvalid}, 32'h0);
        #10;
        rst = 1'b0;

        // write 100 -> 1, 44 -> 31, then read both
        we = 1'b1; waddr = 5'd1;  wdata = 32'd100; step();
        waddr = 5'd31; wdata = 32'd44; step();
        we = 1'b0; re = 2'b11; raddr = {5'd31, 5'd1};
        expect_rd("wr_rd_p0", 1'b0, 0, 32'd100, 1'b1);
        expect_rd("wr_rd_p1", 1'b0, 1, 32'd44, 1'b1);
        step();

        // async reset while both ports are valid; a write under reset is lost
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'd55;
        #2;
        check("rst_rdata0", rdata[31:0], 32'h0);
        check("rst_rdata1", rdata[63:32], 32'h0);
        check("rst_rvalid", {30'h0, rvalid}, 32'h0);
        @(posedge clk);
        #2;
        check("rst_hold_rvalid", {30'h0, rvalid}, 32'h0);
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            re = 2'b11;
            raddr = {5'(31 - i), 5'(i)};
            expect_rd("rst_clear_p0", 1'b0, 0, 32'h0, 1'b1);
            expect_rd("rst_clear_p1", 1'b0, 1, 32'h0, 1'b1);
            step();
        end

        // bypass: write and read of address 7 on the same edge
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; re = 2'b11; raddr = {5'd7, 5'd7};
        expect_rd("byp_p0", 1'b0, 0, 32'hDEADBEEF, 1'b1);
        expect_rd("byp_p1", 1'b0, 1, 32'hDEADBEEF, 1'b1);
        step();
        we = 1'b0; re = 2'b01; raddr = {5'd0, 5'd7};
        expect_rd("byp_stored_p0", 1'b0, 0, 32'hDEADBEEF, 1'b1);
        expect_rd("byp_idle_p1", 1'b0, 1, 32'hDEADBEEF, 1'b0);
        step();

        // zero register: dropped write, and zero beats bypass
        we = 1'b1; waddr = 5'd0; wdata = 32'd9; re = 2'b01; raddr = 10'd0;
        expect_rd("zero_vs_byp", 1'b0, 0, 32'h0, 1'b1);
        step();
        we = 1'b0;
        expect_rd("zero_read", 1'b0, 0, 32'h0, 1'b1);
        step();

        // enable hold
        we = 1'b1; waddr = 5'd5; wdata = 32'd9; re = 2'b00; step();
        we = 1'b0; re = 2'b01; raddr = {5'd0, 5'd5};
        expect_rd("hold_first", 1'b0, 0, 32'd9, 1'b1);
        step();
        re = 2'b00; we = 1'b1; waddr = 5'd5; wdata = 32'd8;
        for (int k = 0; k < 3; k++) begin
            expect_rd("hold", 1'b0, 0, 32'd9, 1'b0);
            step();
        end
        we = 1'b0; re = 2'b01;
        expect_rd("hold_reen", 1'b0, 0, 32'd8, 1'b1);
        step();
        re = 2'b00;

        // 8-bit, 8-deep, 4-port sweep without zero register
        for (int i = 0; i < 8; i++) begin
            s_we = 1'b1; s_waddr = 3'(i); s_wdata = 8'(10 + i);
            step();
        end
        s_we = 1'b0;
        for (int sel = 0; sel < 8; sel++) begin
            s_re = 4'b1111;
            for (int p = 0; p < 4; p++) begin
                s_raddr[p*3 +: 3] = 3'((sel + p) % 8);
                expect_rd("sweep", 1'b1, p, 32'(10 + ((sel + p) % 8)), 1'b1);
            end
            step();
        end
        s_re = 4'b0000;
        s_we = 1'b1; s_waddr = 3'd0; s_wdata = 8'd9; step();
        s_we = 1'b0; s_re = 4'b0001; s_raddr = 12'd0;
        expect_rd("nozero_read", 1'b1, 0, 32'd9, 1'b1);
        step();
        s_re = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
